// File: rtl/dbg_cmd_assembler.sv
// dbg_cmd_assembler: packs a byte-wide host AXI Stream into 32-bit command
// words for the dbg_guv command chain. A partial word left idle too long is
// discarded and counted, so a lost byte cannot misalign framing forever.
module dbg_cmd_assembler #(
  parameter int unsigned BIG_ENDIAN     = 1,
  parameter int unsigned TIMEOUT        = 1000,
  parameter int unsigned TO_WIDTH       = 16,
  parameter int unsigned DROP_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                byte_in_TDATA,
  input  logic                      byte_in_TVALID,
  output logic                      byte_in_TREADY,
  output logic [31:0]               cmd_out_TDATA,
  output logic                      cmd_out_TVALID,
  output logic                      busy,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

  // Idle-count value at which a further idle cycle discards the partial word.
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT - 1);

  logic                      ready_q,  ready_d;
  logic [1:0]                bcnt_q,   bcnt_d;
  logic [TO_WIDTH-1:0]       to_q,     to_d;
  logic [31:0]               shreg_q,  shreg_d;
  logic [31:0]               tdata_q,  tdata_d;
  logic                      tvalid_q, tvalid_d;
  logic                      busy_q,   busy_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q,   drop_d;

  logic        accept;
  logic [1:0]  lane;
  logic [4:0]  lane_lsb;
  logic [31:0] word;

  // Handshake, lane placement, word completion and idle timeout.
  always_comb begin
    ready_d  = 1'b1;
    bcnt_d   = bcnt_q;
    to_d     = to_q;
    shreg_d  = shreg_q;
    tdata_d  = tdata_q;
    tvalid_d = 1'b0;
    drop_d   = drop_q;

    accept   = byte_in_TVALID && ready_q;
    lane     = (BIG_ENDIAN != 0) ? (2'd3 - bcnt_q) : bcnt_q;
    lane_lsb = {lane, 3'b000};
    word     = shreg_q;
    word[lane_lsb +: 8] = byte_in_TDATA;

    if (accept) begin
      shreg_d = word;
      to_d    = '0;
      if (bcnt_q == 2'd3) begin
        tdata_d  = word;
        tvalid_d = 1'b1;
        bcnt_d   = 2'd0;
      end else begin
        bcnt_d = bcnt_q + 2'd1;
      end
    end else if (TIMEOUT != 0 && bcnt_q != 2'd0) begin
      if (to_q == TO_LAST) begin
        bcnt_d = 2'd0;
        to_d   = '0;
        if (drop_q != '1) begin
          drop_d = drop_q + 1'b1;
        end
      end else begin
        to_d = to_q + 1'b1;
      end
    end else begin
      to_d = '0;
    end

    busy_d = (bcnt_d != 2'd0);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ready_q  <= 1'b0;
      bcnt_q   <= 2'd0;
      to_q     <= '0;
      shreg_q  <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      drop_q   <= '0;
    end else begin
      ready_q  <= ready_d;
      bcnt_q   <= bcnt_d;
      to_q     <= to_d;
      shreg_q  <= shreg_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      busy_q   <= busy_d;
      drop_q   <= drop_d;
    end
  end

  assign byte_in_TREADY = ready_q;
  assign cmd_out_TDATA  = tdata_q;
  assign cmd_out_TVALID = tvalid_q;
  assign busy           = busy_q;
  assign drop_cnt       = drop_q;

endmodule

// File: tb/tb_dbg_cmd_assembler.sv
// Bench for dbg_cmd_assembler: two instances share one byte stream
// (big-endian with a 10-cycle timeout and a 2-bit drop counter, and
// little-endian with the timeout disabled), each checked every cycle
// against a queue-of-bytes reference model.
module tb_dbg_cmd_assembler;

  localparam int unsigned NCFG = 2;
  localparam int CFG_BE   [NCFG] = '{1, 0};
  localparam int CFG_TO   [NCFG] = '{10, 0};
  localparam int CFG_DMAX [NCFG] = '{3, 255};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] tdata;
  logic       tvalid;

  logic        a_ready, a_valid, a_busy;
  logic [31:0] a_data;
  logic [1:0]  a_drop;
  logic        b_ready, b_valid, b_busy;
  logic [31:0] b_data;
  logic [7:0]  b_drop;

  dbg_cmd_assembler #(
    .BIG_ENDIAN    (1),
    .TIMEOUT       (10),
    .TO_WIDTH      (16),
    .DROP_CNT_WIDTH(2)
  ) u_be_to (
    .clk           (clk),
    .rst           (rst),
    .byte_in_TDATA (tdata),
    .byte_in_TVALID(tvalid),
    .byte_in_TREADY(a_ready),
    .cmd_out_TDATA (a_data),
    .cmd_out_TVALID(a_valid),
    .busy          (a_busy),
    .drop_cnt      (a_drop)
  );

  dbg_cmd_assembler #(
    .BIG_ENDIAN    (0),
    .TIMEOUT       (0),
    .TO_WIDTH      (16),
    .DROP_CNT_WIDTH(8)
  ) u_le_noto (
    .clk           (clk),
    .rst           (rst),
    .byte_in_TDATA (tdata),
    .byte_in_TVALID(tvalid),
    .byte_in_TREADY(b_ready),
    .cmd_out_TDATA (b_data),
    .cmd_out_TVALID(b_valid),
    .busy          (b_busy),
    .drop_cnt      (b_drop)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: pending bytes per instance, idle-cycle count, drops.
  logic [7:0]  m_q     [NCFG][4];
  int          m_n     [NCFG];
  int          m_idle  [NCFG];
  int          m_drops [NCFG];
  logic        m_valid [NCFG];
  logic [31:0] m_data  [NCFG];
  logic        m_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack(input int c);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      if (CFG_BE[c] != 0) w = w | (32'(m_q[c][i]) << (8 * (3 - i)));
      else                w = w | (32'(m_q[c][i]) << (8 * i));
    end
    return w;
  endfunction

  task automatic model_edge(input logic r, input logic v, input logic [7:0] d);
    logic acc;
    acc = v && m_ready;
    for (int c = 0; c < NCFG; c++) begin
      m_valid[c] = 1'b0;
      if (!r) begin
        m_n[c]     = 0;
        m_idle[c]  = 0;
        m_drops[c] = 0;
        m_data[c]  = '0;
      end else if (acc) begin
        m_q[c][m_n[c]] = d;
        m_n[c]++;
        m_idle[c] = 0;
        if (m_n[c] == 4) begin
          m_data[c]  = pack(c);
          m_valid[c] = 1'b1;
          m_n[c]     = 0;
        end
      end else if (m_n[c] != 0 && CFG_TO[c] != 0) begin
        m_idle[c]++;
        if (m_idle[c] == CFG_TO[c]) begin
          m_n[c]    = 0;
          m_idle[c] = 0;
          if (m_drops[c] < CFG_DMAX[c]) m_drops[c]++;
        end
      end
    end
    m_ready = r;
  endtask

  task automatic check_all();
    check("a_ready", 32'(a_ready), 32'(m_ready));
    check("a_valid", 32'(a_valid), 32'(m_valid[0]));
    check("a_data",  a_data,       m_data[0]);
    check("a_busy",  32'(a_busy),  32'(m_n[0] != 0));
    check("a_drop",  32'(a_drop),  32'(m_drops[0]));
    check("b_ready", 32'(b_ready), 32'(m_ready));
    check("b_valid", 32'(b_valid), 32'(m_valid[1]));
    check("b_data",  b_data,       m_data[1]);
    check("b_busy",  32'(b_busy),  32'(m_n[1] != 0));
    check("b_drop",  32'(b_drop),  32'(m_drops[1]));
  endtask

  // Inputs change at negedge; outputs are checked 1 time unit after posedge.
  task automatic step(input logic v, input logic [7:0] d);
    tvalid = v;
    tdata  = d;
    @(posedge clk);
    model_edge(rst, v, d);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom));
  endtask

  initial begin
    int gap;
    rst    = 1'b0;
    tvalid = 1'b0;
    tdata  = 8'h00;
    @(negedge clk);

    // Reset, then the DEADBEEF word on consecutive cycles.
    idle(3);
    rst = 1'b1;
    step(1'b0, 8'h00);
    step(1'b1, 8'hDE);
    step(1'b1, 8'hAD);
    step(1'b1, 8'hBE);
    step(1'b1, 8'hEF);
    check("be_word",  a_data, 32'hDEADBEEF);
    check("le_word",  b_data, 32'hEFBEADDE);
    check("be_pulse", 32'(a_valid), 32'd1);
    idle(2);
    check("hold_word", a_data, 32'hDEADBEEF);

    // Two bytes then 10 idle cycles: dropped on the big-endian instance.
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    idle(9);
    check("survive_9", 32'(a_busy), 32'd1);
    idle(1);
    check("drop_one",  32'(a_drop), 32'd1);
    check("drop_busy", 32'(a_busy), 32'd0);
    step(1'b1, 8'h01);
    step(1'b1, 8'h02);
    step(1'b1, 8'h03);
    step(1'b1, 8'h04);
    check("after_drop", a_data, 32'h01020304);

    // Byte arriving on the cycle the timeout would fire wins.
    step(1'b1, 8'h55);
    idle(9);
    step(1'b1, 8'h66);
    step(1'b1, 8'h77);
    step(1'b1, 8'h88);
    check("race_word", a_data, 32'h55667788);
    check("race_drop", 32'(a_drop), 32'd1);

    // Drive the 2-bit drop counter into saturation.
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 8'($urandom));
      idle(10);
    end
    check("drop_sat", 32'(a_drop), 32'd3);

    // Randomized bursts with mostly short gaps, occasionally past the timeout.
    for (int k = 0; k < 300; k++) begin
      step(1'b1, 8'($urandom));
      if ($urandom_range(0, 9) == 0) gap = int'($urandom_range(8, 14));
      else                           gap = int'($urandom_range(0, 3));
      idle(gap);
    end

    // Reset mid-word: partial bytes lost, drop counter cleared.
    step(1'b1, 8'hC1);
    step(1'b1, 8'hC2);
    step(1'b1, 8'hC3);
    rst = 1'b0;
    step(1'b1, 8'hC4);
    check("rst_ready", 32'(a_ready), 32'd0);
    step(1'b1, 8'hC5);
    rst = 1'b1;
    step(1'b0, 8'h00);
    step(1'b1, 8'hA1);
    step(1'b1, 8'hA2);
    step(1'b1, 8'hA3);
    step(1'b1, 8'hA4);
    check("post_rst_be",   a_data, 32'hA1A2A3A4);
    check("post_rst_le",   b_data, 32'hA4A3A2A1);
    check("post_rst_drop", 32'(a_drop), 32'd0);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
